vga_tile_display: RTL and testbench
===================================

Name: vga_tile_display

Overview:
Parametrised VGA scan-out engine for the lab's video path. It generates VGA timing, fetches one tile byte per pixel from a synchronous-read video RAM port, and expands packed RGB into DAC-width colour. It is the successor to the fixed 640x480 / 64-pixel-tile renderer. New capabilities: configurable timing, tile size and grid, pipeline-aligned syncs, a CPU-writable frame base with vblank-synchronised page flip, a vblank interrupt pulse and a frame counter. It sits between the video port of the dual-port RAM and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, sync active level for HS (0 = active-low)
VS_POL, 0, sync active level for VS
TILE_SHIFT, 6, log2 of the tile edge in pixels
COLS, 10, tiles per row
ROWS, 8, tile rows
ADDR_W, 8, video address width
COLOR_BITS, 2, bits per channel in vdata (vdata packs R,G,B MSB-first)
OUT_BITS, 8, DAC bits per channel
RESET_BASE, 128, frame base after reset

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
cpu_base  in  ADDR_W  requested frame base address
cpu_base_we  in  1  one-cycle strobe; captures cpu_base as the pending base
vaddr  out  ADDR_W  video RAM read address (registered)
vdata  in  3*COLOR_BITS  RAM data, valid 1 cycle after vaddr
VGA_R, VGA_G, VGA_B  out  OUT_BITS each  colour outputs
VGA_HS, VGA_VS  out  1 each  syncs
vblank_irq  out  1  one-cycle pulse at vblank start
frame_count  out  8  completed-frame counter
active_base  out  ADDR_W  base currently used for scan-out

Behaviour:
- Reset (reset=0, async): h=v=0; RGB=0; HS/VS at their inactive level; vaddr=RESET_BASE; active_base=RESET_BASE; pending flag=0; vblank_irq=0; frame_count=0.
- Counters: h runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800). v increments when h wraps and runs 0..V_TOTAL-1 (525). No extra count at the maximum.
- Stage 0 (counters):
  - sync_h = (h >= H_ACTIVE+H_FP) && (h < H_ACTIVE+H_FP+H_SYNC)
  - sync_v is defined the same way using the V parameters
  - act = (h < H_ACTIVE) && (v < V_ACTIVE)
  - col = h >> TILE_SHIFT; row = v >> TILE_SHIFT; in_grid = (col < COLS) && (row < ROWS)
- Stage 1: vaddr <= active_base + row*COLS + col, truncated to ADDR_W bits (modulo 2^ADDR_W wrap). sync_h, sync_v, act and in_grid are delayed alongside.
- Stage 2: vdata is sampled. Each channel outputs {field replicated} truncated to OUT_BITS (e.g. 2'b10 -> 8'hAA) when act && in_grid, otherwise 0. HS/VS are driven at their active level per HS_POL/VS_POL.
- Total latency from counter value to pins is 2 cycles for colour and syncs alike, so syncs stay aligned to pixels.
- Page flip: cpu_base_we loads pending_base and sets the pending flag; a later write overwrites it. The flip point is the cycle with h==0 and v==V_ACTIVE. At the flip point:
  - If pending is set, active_base <= pending_base and pending is cleared.
  - If cpu_base_we is asserted in that same cycle, cpu_base itself becomes active_base and pending is cleared.
  - vblank_irq=1 for exactly that cycle.
  - frame_count increments, wrapping 255->0.
- active_base never changes outside the flip point, so there is no tearing.
- Reset asserted mid-frame aborts immediately to the reset values. After release, timing restarts at h=v=0.

Decomposition:
- Package vga_pkg holds:
  - the default timing localparams (640x480@60)
  - a packed struct vga_timing_t {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp}
  - the function expand_color(field, OUT_BITS)
- Sub-module vga_timing contains the counters, the sync/active/flip-point generation and stage 0.
- vga_tile_display contains the address pipeline, the page-flip registers and colour expansion.

Test Plan:
- Release reset, default params -> first HS active edge exactly 658 cycles after release; HS active for 96 cycles; line period 800; VS period 420000 cycles.
- RESET_BASE=128, vdata model = address; pixel h=130, v=70 -> vaddr=140 (col 2, row 1), presented 1 cycle later.
- vdata=8'b00_11_01_10 in the active area -> VGA_R=8'hFF, VGA_G=8'h55, VGA_B=8'hAA. During blanking, and at row 7 lines 448..479 versus a grid with ROWS=7 -> RGB=0.
- Write cpu_base=0x40 at v=100 -> active_base stays 128 until h=0, v=480, then becomes 0x40. vblank_irq is a single pulse and frame_count goes 0->1.
- Flip-point collision: pending=0x20, then cpu_base_we with 0x60 exactly at the flip cycle -> active_base=0x60 and pending cleared. Base 0xF8 + offset 12 -> vaddr=0x04 (wrap).
- Assert reset mid-line at h=300, v=200 -> all outputs at reset values within the same cycle (async). frame_count=0; timing restarts from h=v=0 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the timing-set struct and colour expansion helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t TIMING_640X480 = '{
    h_active: 16'(H_ACTIVE_DEF), h_fp: 16'(H_FP_DEF),
    h_sync:   16'(H_SYNC_DEF),   h_bp: 16'(H_BP_DEF),
    v_active: 16'(V_ACTIVE_DEF), v_fp: 16'(V_FP_DEF),
    v_sync:   16'(V_SYNC_DEF),   v_bp: 16'(V_BP_DEF)
  };

  // Repeat the cbits-wide field MSB-first to fill obits output bits (2'b10 -> 8'hAA).
  function automatic logic [31:0] expand_color(input logic [7:0] field,
                                               input int unsigned cbits,
                                               input int unsigned obits);
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < obits; i++) begin
      res[5'(obits - 1 - i)] = field[3'(cbits - 1 - (i % cbits))];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters and stage-0 decode: syncs, active area, tile position, flip point.
module vga_timing
  import vga_pkg::*;
#(
  parameter vga_timing_t T          = TIMING_640X480,
  parameter int unsigned TILE_SHIFT = 6,
  parameter int unsigned COLS       = 10,
  parameter int unsigned ROWS       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_sync_h,
  output logic        o_sync_v,
  output logic        o_act,
  output logic        o_in_grid,
  output logic        o_flip,
  output logic [15:0] o_col,
  output logic [15:0] o_row
);

  localparam int unsigned H_ACT    = 32'(T.h_active);
  localparam int unsigned HS_START = H_ACT + 32'(T.h_fp);
  localparam int unsigned HS_END   = HS_START + 32'(T.h_sync);
  localparam int unsigned H_TOTAL  = HS_END + 32'(T.h_bp);
  localparam int unsigned V_ACT    = 32'(T.v_active);
  localparam int unsigned VS_START = V_ACT + 32'(T.v_fp);
  localparam int unsigned VS_END   = VS_START + 32'(T.v_sync);
  localparam int unsigned V_TOTAL  = VS_END + 32'(T.v_bp);
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [31:0]   w_col;
  logic [31:0]   w_row;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == HW'(H_TOTAL - 1)) begin
      r_h <= '0;
      r_v <= (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  always_comb begin
    w_col     = 32'(r_h) >> TILE_SHIFT;
    w_row     = 32'(r_v) >> TILE_SHIFT;
    o_sync_h  = (32'(r_h) >= HS_START) && (32'(r_h) < HS_END);
    o_sync_v  = (32'(r_v) >= VS_START) && (32'(r_v) < VS_END);
    o_act     = (32'(r_h) < H_ACT) && (32'(r_v) < V_ACT);
    o_in_grid = (w_col < COLS) && (w_row < ROWS);
    o_flip    = (r_h == '0) && (32'(r_v) == V_ACT);
    o_col     = 16'(w_col);
    o_row     = 16'(w_row);
  end

endmodule

// File: rtl/vga_tile_display.sv
// Tile-mapped VGA scan-out: address stage, colour/sync stage and vblank page flip.
module vga_tile_display
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned HS_POL     = 0,
  parameter int unsigned VS_POL     = 0,
  parameter int unsigned TILE_SHIFT = 6,
  parameter int unsigned COLS       = 10,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned COLOR_BITS = 2,
  parameter int unsigned OUT_BITS   = 8,
  parameter int unsigned RESET_BASE = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         cpu_base,
  input  logic                      cpu_base_we,
  output logic [ADDR_W-1:0]         vaddr,
  input  logic [3*COLOR_BITS-1:0]   vdata,
  output logic [OUT_BITS-1:0]       VGA_R,
  output logic [OUT_BITS-1:0]       VGA_G,
  output logic [OUT_BITS-1:0]       VGA_B,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      vblank_irq,
  output logic [7:0]                frame_count,
  output logic [ADDR_W-1:0]         active_base
);

  localparam vga_timing_t TIMING = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  };
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic              w_sync_h, w_sync_v, w_act, w_in_grid, w_flip;
  logic [15:0]       w_col, w_row;
  logic [ADDR_W-1:0] w_offset;
  logic [OUT_BITS-1:0] w_r, w_g, w_b;

  logic [ADDR_W-1:0] r_vaddr;
  logic              r_s1_hs, r_s1_vs, r_s1_vis;
  logic [OUT_BITS-1:0] r_r, r_g, r_b;
  logic              r_hs, r_vs;
  logic [ADDR_W-1:0] r_active_base, r_pending_base;
  logic              r_pending;
  logic [7:0]        r_frame_count;

  vga_timing #(
    .T          (TIMING),
    .TILE_SHIFT (TILE_SHIFT),
    .COLS       (COLS),
    .ROWS       (ROWS)
  ) u_timing (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .o_sync_h  (w_sync_h),
    .o_sync_v  (w_sync_v),
    .o_act     (w_act),
    .o_in_grid (w_in_grid),
    .o_flip    (w_flip),
    .o_col     (w_col),
    .o_row     (w_row)
  );

  assign w_offset = ADDR_W'(32'(w_row) * COLS + 32'(w_col));

  always_comb begin
    w_r = OUT_BITS'(expand_color(8'(vdata[3*COLOR_BITS-1 -: COLOR_BITS]), COLOR_BITS, OUT_BITS));
    w_g = OUT_BITS'(expand_color(8'(vdata[2*COLOR_BITS-1 -: COLOR_BITS]), COLOR_BITS, OUT_BITS));
    w_b = OUT_BITS'(expand_color(8'(vdata[COLOR_BITS-1:0]), COLOR_BITS, OUT_BITS));
  end

  // Stage 1: RAM address; sync/visibility travel with it so pins stay pixel-aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vaddr  <= ADDR_W'(RESET_BASE);
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
      r_s1_vis <= 1'b0;
    end else begin
      r_vaddr  <= r_active_base + w_offset;
      r_s1_hs  <= w_sync_h;
      r_s1_vs  <= w_sync_v;
      r_s1_vis <= w_act && w_in_grid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
      r_hs <= ~HS_ON;
      r_vs <= ~VS_ON;
    end else begin
      r_r  <= r_s1_vis ? w_r : '0;
      r_g  <= r_s1_vis ? w_g : '0;
      r_b  <= r_s1_vis ? w_b : '0;
      r_hs <= r_s1_hs ? HS_ON : ~HS_ON;
      r_vs <= r_s1_vs ? VS_ON : ~VS_ON;
    end
  end

  // A write landing on the flip cycle itself takes effect immediately and supersedes pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active_base  <= ADDR_W'(RESET_BASE);
      r_pending_base <= '0;
      r_pending      <= 1'b0;
      r_frame_count  <= '0;
    end else if (w_flip) begin
      r_frame_count <= r_frame_count + 1'b1;
      r_pending     <= 1'b0;
      if (cpu_base_we)
        r_active_base <= cpu_base;
      else if (r_pending)
        r_active_base <= r_pending_base;
    end else if (cpu_base_we) begin
      r_pending_base <= cpu_base;
      r_pending      <= 1'b1;
    end
  end

  assign vaddr       = r_vaddr;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign vblank_irq  = w_flip;
  assign frame_count = r_frame_count;
  assign active_base = r_active_base;

endmodule

// File: tb/tb_vga_tile_display.sv
// Scaled-timing bench: 96x64 active, 8-pixel tiles, 10x7 grid, RAM model feeding vdata.
`timescale 1ns/1ps
module tb_vga_tile_display;

  localparam int HA = 96, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 64, VF = 2, VSY = 2, VB = 4;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int LIMIT = HT * VT + 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] cpu_base = 8'h00;
  logic       cpu_base_we = 1'b0;
  logic [7:0] vaddr;
  logic [5:0] vdata;
  logic [7:0] vr, vg, vb;
  logic       hs, vs, irq;
  logic [7:0] fc, ab;
  logic [5:0] mem [256];

  assign vdata = mem[vaddr];
  always #5 clk = ~clk;

  vga_tile_display #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .TILE_SHIFT(3), .COLS(10), .ROWS(7),
    .ADDR_W(8), .COLOR_BITS(2), .OUT_BITS(8), .RESET_BASE(128)
  ) dut (
    .clk(clk), .reset(rst_n), .cpu_base(cpu_base), .cpu_base_we(cpu_base_we),
    .vaddr(vaddr), .vdata(vdata), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
    .VGA_HS(hs), .VGA_VS(vs), .vblank_irq(irq), .frame_count(fc), .active_base(ab)
  );

  int cyc, th, tv;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; th <= 0; tv <= 0;
    end else begin
      cyc <= cyc + 1;
      if (th == HT - 1) begin
        th <= 0;
        tv <= (tv == VT - 1) ? 0 : tv + 1;
      end else th <= th + 1;
    end
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {int due; bit pins; logic [7:0] addr; logic [23:0] rgb; logic hs; logic vs; int id;} exp_t;
  exp_t sb[$];

  function automatic logic [23:0] exp_col(input logic [5:0] d);
    return {{4{d[5:4]}}, {4{d[3:2]}}, {4{d[1:0]}}};
  endfunction

  task automatic sb_push(input int id, input logic [7:0] a, input logic vis, input logic h, input logic v);
    exp_t e;
    e.due = cyc + 1; e.pins = 1'b0; e.addr = a; e.rgb = '0; e.hs = h; e.vs = v; e.id = id;
    sb.push_back(e);
    e.due = cyc + 2; e.pins = 1'b1; e.rgb = vis ? exp_col(mem[a]) : 24'h0;
    sb.push_back(e);
  endtask

  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.pins) chk($sformatf("vaddr[%0d]", e.id), 32'(vaddr), 32'(e.addr));
      else begin
        chk($sformatf("rgb[%0d]", e.id), {8'h0, vr, vg, vb}, {8'h0, e.rgb});
        chk($sformatf("hs[%0d]", e.id), 32'(hs), 32'(e.hs));
        chk($sformatf("vs[%0d]", e.id), 32'(vs), 32'(e.vs));
      end
    end
  end

  int hs_f[2], hs_r0, vs_f[2];
  int nhf = 0, nhr = 0, nvf = 0;
  logic phs = 1'b1, pvs = 1'b1;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      nhf = 0; nhr = 0; nvf = 0; phs = 1'b1; pvs = 1'b1;
    end else begin
      if (phs && !hs) begin if (nhf < 2) hs_f[nhf] = cyc; nhf++; end
      if (!phs && hs && nhr == 0) begin hs_r0 = cyc; nhr++; end
      if (pvs && !vs) begin if (nvf < 2) vs_f[nvf] = cyc; nvf++; end
      phs = hs; pvs = vs;
    end
  end

  task automatic wait_pos(input int h, input int v);
    int k;
    k = 0;
    while (!(th == h && tv == v) && k < LIMIT) begin @(negedge clk); k++; end
    if (!(th == h && tv == v)) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_pos(%0d,%0d): timed out at h=%0d v=%0d", h, v, th, tv);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    cpu_base = b; cpu_base_we = 1'b1;
    @(negedge clk);
    cpu_base_we = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vaddr"}, 32'(vaddr), 32'd128);
    chk({tag, "_rgb"}, {8'h0, vr, vg, vb}, 32'h0);
    chk({tag, "_hs"}, 32'(hs), 32'd1);
    chk({tag, "_vs"}, 32'(vs), 32'd1);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_fc"}, 32'(fc), 32'd0);
    chk({tag, "_base"}, 32'(ab), 32'd128);
  endtask

  typedef struct {int h; int v; logic [7:0] a; logic vis; logic hs; logic vs;} vec_t;
  vec_t vt[16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 6'($urandom_range(1, 63));
    mem[164] = 6'b11_01_10;
    vt[0]  = '{0,   0,  8'd128, 1'b1, 1'b1, 1'b1};
    vt[1]  = '{99,  2,  8'd140, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{100, 2,  8'd140, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{107, 2,  8'd141, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{108, 2,  8'd141, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{79,  5,  8'd137, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{80,  5,  8'd138, 1'b0, 1'b1, 1'b1};
    vt[7]  = '{17,  9,  8'd140, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{50,  30, 8'd164, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{79,  55, 8'd197, 1'b1, 1'b1, 1'b1};
    vt[10] = '{8,   56, 8'd199, 1'b0, 1'b1, 1'b1};
    vt[11] = '{8,   63, 8'd199, 1'b0, 1'b1, 1'b1};
    vt[12] = '{20,  65, 8'd210, 1'b0, 1'b1, 1'b1};
    vt[13] = '{20,  66, 8'd210, 1'b0, 1'b1, 1'b0};
    vt[14] = '{20,  67, 8'd210, 1'b0, 1'b1, 1'b0};
    vt[15] = '{20,  68, 8'd210, 1'b0, 1'b1, 1'b1};

    #1 rst_n = 1'b0;
    #1 chk_reset_state("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wait_pos(vt[i].h, vt[i].v);
      sb_push(i, vt[i].a, vt[i].vis, vt[i].hs, vt[i].vs);
    end
    repeat (3) @(negedge clk);
    chk("hs_first", 32'(hs_f[0]), 32'(HA + HF + 2));
    chk("hs_width", 32'(hs_r0 - hs_f[0]), 32'(HSY));
    chk("hs_period", 32'(hs_f[1] - hs_f[0]), 32'(HT));
    chk("fc_frame0", 32'(fc), 32'd1);
    chk("base_frame0", 32'(ab), 32'd128);

    // frame 1: mid-frame write must wait for the flip point
    wait_pos(0, 30);
    strobe(8'h40);
    wait_pos(HT - 1, VA - 1);
    chk("base_preflip", 32'(ab), 32'd128);
    chk("irq_preflip", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_flip", 32'(irq), 32'd1);
    chk("base_atflip", 32'(ab), 32'd128);
    chk("fc_atflip", 32'(fc), 32'd1);
    @(negedge clk);
    chk("irq_postflip", 32'(irq), 32'd0);
    chk("base_postflip", 32'(ab), 32'h40);
    chk("fc_postflip", 32'(fc), 32'd2);

    // frame 2: pending 0x20, then a write exactly on the flip cycle wins
    wait_pos(17, 9);
    sb_push(20, 8'h4C, 1'b1, 1'b1, 1'b1);
    wait_pos(0, 10);
    strobe(8'h20);
    wait_pos(0, VA);
    chk("irq_collide", 32'(irq), 32'd1);
    strobe(8'h60);
    chk("base_collide", 32'(ab), 32'h60);
    chk("fc_collide", 32'(fc), 32'd3);
    chk("vs_period", 32'(vs_f[1] - vs_f[0]), 32'(HT * VT));

    // frame 3: no writes, pending must have been cleared
    wait_pos(17, 9);
    sb_push(21, 8'h6C, 1'b1, 1'b1, 1'b1);
    wait_pos(0, VA);
    @(negedge clk);
    chk("base_nopend", 32'(ab), 32'h60);
    chk("fc_nopend", 32'(fc), 32'd4);

    // frame 4: a later write overwrites the pending base
    wait_pos(0, 5);
    strobe(8'h10);
    wait_pos(0, 20);
    strobe(8'hF8);
    wait_pos(0, VA);
    @(negedge clk);
    chk("base_overwrite", 32'(ab), 32'hF8);
    chk("fc_overwrite", 32'(fc), 32'd5);

    // frame 5: base 0xF8 + offset 12 wraps to 0x04
    wait_pos(17, 9);
    sb_push(22, 8'h04, 1'b1, 1'b1, 1'b1);

    wait_pos(60, 20);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_pos(17, 9);
    sb_push(23, 8'd140, 1'b1, 1'b1, 1'b1);
    chk("hs_first_restart", 32'(hs_f[0]), 32'(HA + HF + 2));
    chk("fc_restart", 32'(fc), 32'd0);
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
